huff_tx_sched: RTL and testbench
================================

# huff_tx_sched

Sequences the Huffman encoder's serial output stage. It snapshots the ten-entry code table at the start of a frame, then accepts symbol indices over a valid/ready handshake. Each symbol is expanded into its variable-length codeword, emitted MSB-first one bit per clock. Frame completion is signalled with a bit count, and illegal symbols or table entries are flagged. The block sits between the symbol source (input buffer) and the serial line driver, after code generation has produced Code0..Code9.

## Interface
- CNT_W, 16, width of the frame bit counter Total_bits
- Clk_in  in  1  system clock, all state on rising edge
- n_Rst  in  1  asynchronous, active-low reset
- Start  in  1  begin a frame; sampled only in IDLE
- Code0..Code9  in  13 each  code table entry per symbol:
  - [12:9] = length L, legal range 1..9
  - [8:0] = codeword, right-aligned; only bits [L-1:0] are used
- Sym  in  4  symbol index, legal range 0..9
- Sym_vld  in  1  Sym valid
- Sym_last  in  1  qualifies Sym as the final symbol of the frame
- Sym_rdy  out  1  block accepts Sym this cycle
- Bit_out  out  1  serial code bit, registered
- Bit_vld  out  1  Bit_out carries a code bit this cycle
- Fin  out  1  one-cycle pulse: frame completed cleanly
- Err  out  1  sticky error flag; cleared by the next accepted Start
- Busy  out  1  high in every state except IDLE
- Total_bits  out  CNT_W  bits emitted in the current or last frame; saturates at all-ones
- State  out  3  FSM state code, for debug

## Operation
- FSM states:
  - IDLE=0
  - FETCH=1
  - SHIFT=2
  - DONE=3
  - ERR=4
- IDLE:
  - Start=1: latch Code0..Code9 into an internal table, clear Total_bits, clear Err, go to FETCH.
  - Start=0: remain in IDLE.
  - Code inputs are ignored outside this single sampling cycle.
- FETCH:
  - Sym_rdy=1. A transfer occurs when Sym_vld && Sym_rdy.
  - On transfer, look up entry e = table[Sym]. If Sym>9, or e.L==0, or e.L>9, go to ERR.
  - Otherwise, on a good transfer:
    - load shift register with e.code;
    - set bit index = L-1;
    - latch Sym_last into a last flag;
    - go to SHIFT.
  - Sym_vld=0: stall in FETCH with Bit_vld=0.
- SHIFT:
  - Bit_out = code[index] and Bit_vld=1 every cycle; index decrements each cycle.
  - Total_bits increments by 1 per emitted bit, saturating.
  - On the final bit (index==0):
    - if the last flag is clear: Sym_rdy=1, and a transfer in that cycle is checked and loaded exactly as in FETCH, then SHIFT continues with the new symbol with no idle cycle;
    - if no transfer occurs: go to FETCH;
    - if the last flag is set: Sym_rdy=0, go to DONE.
- DONE: Fin=1 for one cycle, then IDLE. Total_bits holds its value until the next Start.
- ERR:
  - Err set; go to IDLE next cycle; no Fin.
  - The offending symbol emits no bits. Bits already emitted remain counted.
- Start outside IDLE is ignored and has no effect on the table.
- Sym_last on an illegal symbol: ERR takes priority; the frame ends without Fin.

## Timing
- Reset values: Sym_rdy=0, Bit_out=0, Bit_vld=0, Fin=0, Err=0, Busy=0, Total_bits=0, State=IDLE. The table clears to all zero.
- Reset is asynchronous at any point, including mid-codeword. It aborts the frame immediately, with no partial Fin.
- Start sampled at edge k: Busy=1 and Sym_rdy=1 from cycle k+1.
- Symbol accepted at edge m: its first bit is on Bit_out during cycle m+1. A length-L code occupies exactly L consecutive Bit_vld cycles.
- Back-to-back symbols: 100% bit utilisation when Sym_vld is held high.
- Last symbol's final bit in cycle n: Fin=1 in cycle n+1, IDLE in cycle n+2. Total_bits is final when Fin=1.
- Illegal symbol accepted at edge m: Err=1 from cycle m+1 onward, IDLE at cycle m+2.

## Test plan
- Load table {0x0401,0x0607,0x0601,0x0808,0x0605,0x0809,0x0a01,0x0801,0x0a00,0x0606}, Start, then stream Sym 0,1,2 (last on 2) with Sym_vld held high -> Bit_out=0,1,1,1,1,0,0,1 on 8 contiguous Bit_vld cycles, Fin one cycle later, Total_bits=8, Err=0.
- Same table, Sym 8 then 3 (last), with Sym_vld dropped for 3 cycles between them -> bits 00000, then 3 cycles with Bit_vld=0 in FETCH, then 1000; Total_bits=9.
- Sym=12 after a good Sym 0 -> bits 0,1, then Err=1, no Fin, Total_bits=2, IDLE two cycles after acceptance. Next Start clears Err.
- Change Code0 to 0x0000 mid-frame, then send Sym 0 -> still emits 0,1 (snapshot used). Table entry of length 0 loaded at Start -> Err on that symbol.
- Pulse Start while in SHIFT -> no effect on bits or Total_bits.
- Assert n_Rst=0 mid-codeword -> all outputs return to reset values asynchronously; a fresh Start works normally.

Source files
------------

// File: rtl/huff_tx_sched.sv
// Huffman serial output scheduler: snapshots the code table on Start, then
// expands each accepted symbol into its codeword, MSB-first, one bit per clock.
module huff_tx_sched #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             Clk_in,
  input  logic             n_Rst,
  input  logic             Start,
  input  logic [12:0]      Code0,
  input  logic [12:0]      Code1,
  input  logic [12:0]      Code2,
  input  logic [12:0]      Code3,
  input  logic [12:0]      Code4,
  input  logic [12:0]      Code5,
  input  logic [12:0]      Code6,
  input  logic [12:0]      Code7,
  input  logic [12:0]      Code8,
  input  logic [12:0]      Code9,
  input  logic [3:0]       Sym,
  input  logic             Sym_vld,
  input  logic             Sym_last,
  output logic             Sym_rdy,
  output logic             Bit_out,
  output logic             Bit_vld,
  output logic             Fin,
  output logic             Err,
  output logic             Busy,
  output logic [CNT_W-1:0] Total_bits,
  output logic [2:0]       State
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_SHIFT = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [12:0] code_in [10];
  logic [12:0] tbl_q   [10];
  logic [12:0] entry;
  logic [3:0]  ent_len;
  logic [8:0]  code_q;
  logic [3:0]  idx_q;
  logic        last_q;
  logic        start_acc, sym_ok, last_bit, xfer, load, bad, step, emit;

  assign code_in[0] = Code0;
  assign code_in[1] = Code1;
  assign code_in[2] = Code2;
  assign code_in[3] = Code3;
  assign code_in[4] = Code4;
  assign code_in[5] = Code5;
  assign code_in[6] = Code6;
  assign code_in[7] = Code7;
  assign code_in[8] = Code8;
  assign code_in[9] = Code9;

  // Out-of-range symbols look up an all-zero entry, which fails the length check.
  always_comb begin
    entry = '0;
    for (int unsigned i = 0; i < 10; i++) begin
      if (Sym == 4'(i)) entry = tbl_q[i];
    end
  end

  assign ent_len   = entry[12:9];
  assign sym_ok    = (ent_len != 4'd0) && (ent_len <= 4'd9);
  assign start_acc = (state_q == S_IDLE) && Start;
  assign last_bit  = (state_q == S_SHIFT) && (idx_q == 4'd0);
  assign Sym_rdy   = (state_q == S_FETCH) || (last_bit && !last_q);
  assign xfer      = Sym_vld && Sym_rdy;
  assign load      = xfer && sym_ok;
  assign bad       = xfer && !sym_ok;
  assign step      = (state_q == S_SHIFT) && (idx_q != 4'd0);
  assign emit      = load || step;

  assign Fin   = (state_q == S_DONE);
  assign Busy  = (state_q != S_IDLE);
  assign State = state_q;

  always_ff @(posedge Clk_in or negedge n_Rst) begin
    if (!n_Rst) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (Start) state_d = S_FETCH;
      S_FETCH: begin
        if (load)     state_d = S_SHIFT;
        else if (bad) state_d = S_ERR;
      end
      S_SHIFT: begin
        if (idx_q == 4'd0) begin
          if (last_q)    state_d = S_DONE;
          else if (load) state_d = S_SHIFT;
          else if (bad)  state_d = S_ERR;
          else           state_d = S_FETCH;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk_in or negedge n_Rst) begin
    if (!n_Rst) begin
      for (int unsigned i = 0; i < 10; i++) tbl_q[i] <= '0;
    end else if (start_acc) begin
      for (int unsigned i = 0; i < 10; i++) tbl_q[i] <= code_in[i];
    end
  end

  // Bit_out is registered: the first bit of a symbol is presented on the
  // edge that accepts it, so idx_q always names the bit currently on the line.
  always_ff @(posedge Clk_in or negedge n_Rst) begin
    if (!n_Rst) begin
      code_q     <= '0;
      idx_q      <= '0;
      last_q     <= 1'b0;
      Bit_out    <= 1'b0;
      Bit_vld    <= 1'b0;
      Total_bits <= '0;
      Err        <= 1'b0;
    end else begin
      Bit_vld <= emit;
      if (load) begin
        code_q  <= entry[8:0];
        idx_q   <= ent_len - 4'd1;
        last_q  <= Sym_last;
        Bit_out <= entry[ent_len - 4'd1];
      end else if (step) begin
        idx_q   <= idx_q - 4'd1;
        Bit_out <= code_q[idx_q - 4'd1];
      end else begin
        Bit_out <= 1'b0;
      end
      if (start_acc)
        Total_bits <= '0;
      else if (emit && (Total_bits != '1))
        Total_bits <= Total_bits + CNT_W'(1);
      if (start_acc) Err <= 1'b0;
      else if (bad)  Err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_huff_tx_sched.sv
// Scenario bench for huff_tx_sched: expected bits are queued from a table model
// when symbols are handed over and compared against the captured serial stream.
module tb_huff_tx_sched;

  localparam int unsigned TBW = 4;

  logic           clk = 1'b0;
  logic           n_rst;
  logic           start;
  logic [12:0]    code_in [10];
  logic [3:0]     sym;
  logic           sym_vld, sym_last;
  logic           sym_rdy, bit_out, bit_vld, fin, err, busy;
  logic [TBW-1:0] total_bits;
  logic [2:0]     state;

  huff_tx_sched #(.CNT_W(TBW)) dut (
    .Clk_in(clk), .n_Rst(n_rst), .Start(start),
    .Code0(code_in[0]), .Code1(code_in[1]), .Code2(code_in[2]), .Code3(code_in[3]),
    .Code4(code_in[4]), .Code5(code_in[5]), .Code6(code_in[6]), .Code7(code_in[7]),
    .Code8(code_in[8]), .Code9(code_in[9]),
    .Sym(sym), .Sym_vld(sym_vld), .Sym_last(sym_last), .Sym_rdy(sym_rdy),
    .Bit_out(bit_out), .Bit_vld(bit_vld), .Fin(fin), .Err(err), .Busy(busy),
    .Total_bits(total_bits), .State(state)
  );

  always #5 clk = ~clk;

  int             n_chk = 0;
  int             n_pass = 0;
  int             cyc = 0;
  logic [12:0]    snap [10];
  logic [12:0]    tbl_t [10];
  bit             exp_q [$];
  bit             obs_q [$];
  int             obs_c [$];
  int             fin_c [$];
  int             exp_n;
  logic [TBW-1:0] fin_tot;
  logic           fin_err;

  always @(negedge clk) begin
    cyc++;
    if (bit_vld === 1'b1) begin
      obs_q.push_back(bit_out);
      obs_c.push_back(cyc);
    end
    if (fin === 1'b1) begin
      fin_c.push_back(cyc);
      fin_tot = total_bits;
      fin_err = err;
    end
  end

  task automatic start_frame();
    @(negedge clk);
    exp_q.delete(); obs_q.delete(); obs_c.delete(); fin_c.delete();
    exp_n = 0;
    for (int i = 0; i < 10; i++) snap[i] = code_in[i];
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Hold the symbol until the handshake completes; queue its modelled bits.
  task automatic put_sym(input logic [3:0] s, input logic l, output bit ok);
    logic [12:0] e;
    int          len;
    ok = 1'b0;
    sym = s; sym_last = l; sym_vld = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (sym_rdy === 1'b1) begin
        @(negedge clk);
        ok = 1'b1;
        if (s <= 4'd9) begin
          e = snap[s];
          len = int'(e[12:9]);
          if (len >= 1 && len <= 9)
            for (int b = len - 1; b >= 0; b--) begin
              exp_q.push_back(e[b]);
              exp_n++;
            end
        end
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic idle_cycles(input int n);
    sym_vld = 1'b0;
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_chk++; if ({sym_rdy, bit_out, bit_vld, fin, err, busy} !== 6'b0)
      $display("FAIL reset_flags: got %b want 000000", {sym_rdy, bit_out, bit_vld, fin, err, busy});
    else n_pass++;
    n_chk++; if (total_bits !== '0) $display("FAIL reset_total: got %0d want 0", total_bits); else n_pass++;
    n_chk++; if (state !== 3'd0) $display("FAIL reset_state: got %0d want 0", state); else n_pass++;
  endtask

  task automatic test_stream();
    bit ok0, ok1, ok2, eb, ob;
    logic [7:0] w;
    for (int i = 0; i < 10; i++) code_in[i] = tbl_t[i];
    start_frame();
    n_chk++; if ({busy, sym_rdy} !== 2'b11) $display("FAIL stream_start: got busy,rdy=%b want 11", {busy, sym_rdy}); else n_pass++;
    put_sym(4'd0, 1'b0, ok0);
    put_sym(4'd1, 1'b0, ok1);
    put_sym(4'd2, 1'b1, ok2);
    idle_cycles(12);
    n_chk++; if ({ok0, ok1, ok2} !== 3'b111) $display("FAIL stream_accept: got %b want 111", {ok0, ok1, ok2}); else n_pass++;
    w = '0;
    for (int i = 0; i < 8 && i < obs_q.size(); i++) w = {w[6:0], obs_q[i]};
    n_chk++; if (w !== 8'b01111001) $display("FAIL stream_pattern: got %b want 01111001", w); else n_pass++;
    n_chk++; if (obs_c.size() != 8 || obs_c[7] - obs_c[0] != 7)
      $display("FAIL stream_contig: got %0d bits, span %0d want 8 bits span 7", obs_c.size(), obs_c.size() ? obs_c[obs_c.size()-1] - obs_c[0] : -1);
    else n_pass++;
    n_chk++; if (fin_c.size() != 1 || obs_c.size() == 0 || fin_c[0] != obs_c[obs_c.size()-1] + 1)
      $display("FAIL stream_fin: got %0d pulses want 1 right after last bit", fin_c.size());
    else n_pass++;
    n_chk++; if ({fin_err, fin_tot} !== {1'b0, 4'd8}) $display("FAIL stream_total: got err=%b total=%0d want err=0 total=8", fin_err, fin_tot); else n_pass++;
    n_chk++; if ({busy, state} !== 4'b0000) $display("FAIL stream_idle: got busy=%b state=%0d want 0/0", busy, state); else n_pass++;
    while (exp_q.size() > 0) begin
      eb = exp_q.pop_front(); n_chk++;
      if (obs_q.size() == 0) $display("FAIL stream_bit: got none want %b", eb);
      else begin ob = obs_q.pop_front(); if (ob !== eb) $display("FAIL stream_bit: got %b want %b", ob, eb); else n_pass++; end
    end
  endtask

  task automatic test_stall();
    bit ok0, ok1, eb, ob;
    start_frame();
    put_sym(4'd8, 1'b0, ok0);
    sym_vld = 1'b0;
    repeat (7) @(negedge clk);
    put_sym(4'd3, 1'b1, ok1);
    idle_cycles(10);
    n_chk++; if ({ok0, ok1} !== 2'b11) $display("FAIL stall_accept: got %b want 11", {ok0, ok1}); else n_pass++;
    n_chk++; if (obs_c.size() != 9 || obs_c[5] - obs_c[4] - 1 != 3 || obs_c[4] - obs_c[0] != 4)
      $display("FAIL stall_gap: got %0d bits gap %0d want 9 bits gap 3", obs_c.size(), obs_c.size() == 9 ? obs_c[5] - obs_c[4] - 1 : -1);
    else n_pass++;
    n_chk++; if ({fin_c.size() == 1, fin_tot} !== {1'b1, 4'd9}) $display("FAIL stall_total: got fins=%0d total=%0d want 1/9", fin_c.size(), fin_tot); else n_pass++;
    while (exp_q.size() > 0) begin
      eb = exp_q.pop_front(); n_chk++;
      if (obs_q.size() == 0) $display("FAIL stall_bit: got none want %b", eb);
      else begin ob = obs_q.pop_front(); if (ob !== eb) $display("FAIL stall_bit: got %b want %b", ob, eb); else n_pass++; end
    end
  endtask

  task automatic test_illegal();
    bit ok0, ok1, eb, ob;
    start_frame();
    put_sym(4'd0, 1'b0, ok0);
    put_sym(4'd12, 1'b1, ok1);
    n_chk++; if ({ok0, ok1, err, state} !== {3'b111, 3'd4}) $display("FAIL illegal_err: got ok=%b%b err=%b state=%0d want 11/1/4", ok0, ok1, err, state); else n_pass++;
    sym_vld = 1'b0;
    @(negedge clk);
    n_chk++; if ({busy, err, state} !== {2'b01, 3'd0}) $display("FAIL illegal_idle: got busy=%b err=%b state=%0d want 0/1/0", busy, err, state); else n_pass++;
    idle_cycles(5);
    n_chk++; if ({fin_c.size() == 0, total_bits} !== {1'b1, 4'd2}) $display("FAIL illegal_total: got fins=%0d total=%0d want 0/2", fin_c.size(), total_bits); else n_pass++;
    while (exp_q.size() > 0) begin
      eb = exp_q.pop_front(); n_chk++;
      if (obs_q.size() == 0) $display("FAIL illegal_bit: got none want %b", eb);
      else begin ob = obs_q.pop_front(); if (ob !== eb) $display("FAIL illegal_bit: got %b want %b", ob, eb); else n_pass++; end
    end
    n_chk++; if (obs_q.size() != 0) $display("FAIL illegal_extra: got %0d extra bits want 0", obs_q.size()); else n_pass++;
    start_frame();
    n_chk++; if (err !== 1'b0) $display("FAIL illegal_clear: got err=%b want 0", err); else n_pass++;
    put_sym(4'd4, 1'b1, ok0);
    idle_cycles(6);
    n_chk++; if ({ok0, obs_q.size() == 3, obs_q[0], obs_q[1], obs_q[2], fin_c.size() == 1} !== 6'b111011)
      $display("FAIL illegal_next: got ok=%b bits=%0d fins=%0d want 1, 101, 1", ok0, obs_q.size(), fin_c.size());
    else n_pass++;
  endtask

  task automatic test_snapshot();
    bit ok0;
    start_frame();
    code_in[0] = 13'h0000;
    put_sym(4'd0, 1'b1, ok0);
    idle_cycles(6);
    n_chk++; if ({ok0, obs_q.size() == 2, obs_q[0], obs_q[1], fin_c.size() == 1, total_bits} !== {5'b11011, 4'd2})
      $display("FAIL snap_used: got ok=%b bits=%0d fins=%0d total=%0d want 1, 01, 1, 2", ok0, obs_q.size(), fin_c.size(), total_bits);
    else n_pass++;
    code_in[0] = tbl_t[0];
    code_in[5] = 13'h0000;
    start_frame();
    put_sym(4'd5, 1'b1, ok0);
    n_chk++; if ({ok0, err, state} !== {2'b11, 3'd4}) $display("FAIL snap_len0: got ok=%b err=%b state=%0d want 1/1/4", ok0, err, state); else n_pass++;
    idle_cycles(3);
    code_in[5] = 13'h1401;
    start_frame();
    n_chk++; if (err !== 1'b0) $display("FAIL snap_clear: got err=%b want 0", err); else n_pass++;
    put_sym(4'd5, 1'b1, ok0);
    n_chk++; if ({ok0, err} !== 2'b11) $display("FAIL snap_len10: got ok=%b err=%b want 1/1", ok0, err); else n_pass++;
    idle_cycles(3);
    n_chk++; if ({obs_q.size() == 0, fin_c.size() == 0} !== 2'b11) $display("FAIL snap_quiet: got bits=%0d fins=%0d want 0/0", obs_q.size(), fin_c.size()); else n_pass++;
    code_in[5] = tbl_t[5];
  endtask

  task automatic test_bounds();
    bit ok0, ok1, ok2, eb, ob;
    code_in[9] = 13'h1355;
    start_frame();
    put_sym(4'd9, 1'b0, ok0);
    put_sym(4'd9, 1'b0, ok1);
    put_sym(4'd10, 1'b1, ok2);
    idle_cycles(4);
    n_chk++; if ({ok0, ok1, ok2, err, fin_c.size() == 0} !== 5'b11111) $display("FAIL bounds_err: got ok=%b%b%b err=%b fins=%0d want 111/1/0", ok0, ok1, ok2, err, fin_c.size()); else n_pass++;
    n_chk++; if (total_bits !== TBW'(exp_n > 15 ? 15 : exp_n)) $display("FAIL bounds_sat: got %0d want 15", total_bits); else n_pass++;
    while (exp_q.size() > 0) begin
      eb = exp_q.pop_front(); n_chk++;
      if (obs_q.size() == 0) $display("FAIL bounds_bit: got none want %b", eb);
      else begin ob = obs_q.pop_front(); if (ob !== eb) $display("FAIL bounds_bit: got %b want %b", ob, eb); else n_pass++; end
    end
    code_in[9] = tbl_t[9];
  endtask

  task automatic test_start_in_shift();
    bit ok0, ok1, eb, ob;
    start_frame();
    put_sym(4'd6, 1'b0, ok0);
    sym_vld = 1'b0;
    for (int i = 0; i < 10; i++) code_in[i] = 13'h0000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    put_sym(4'd1, 1'b1, ok1);
    idle_cycles(8);
    for (int i = 0; i < 10; i++) code_in[i] = tbl_t[i];
    n_chk++; if ({ok0, ok1, fin_c.size() == 1, fin_tot} !== {3'b111, 4'd8}) $display("FAIL shift_start: got ok=%b%b fins=%0d total=%0d want 11/1/8", ok0, ok1, fin_c.size(), fin_tot); else n_pass++;
    while (exp_q.size() > 0) begin
      eb = exp_q.pop_front(); n_chk++;
      if (obs_q.size() == 0) $display("FAIL shift_bit: got none want %b", eb);
      else begin ob = obs_q.pop_front(); if (ob !== eb) $display("FAIL shift_bit: got %b want %b", ob, eb); else n_pass++; end
    end
  endtask

  task automatic test_reset_mid();
    bit ok0;
    start_frame();
    put_sym(4'd3, 1'b1, ok0);
    sym_vld = 1'b0;
    @(negedge clk);
    #2 n_rst = 1'b0;
    #1;
    n_chk++; if ({ok0, sym_rdy, bit_out, bit_vld, fin, err, busy} !== 7'b1000000)
      $display("FAIL rstmid_flags: got ok=%b flags=%b want 1/000000", ok0, {sym_rdy, bit_out, bit_vld, fin, err, busy});
    else n_pass++;
    n_chk++; if ({total_bits, state} !== 7'd0) $display("FAIL rstmid_state: got total=%0d state=%0d want 0/0", total_bits, state); else n_pass++;
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    idle_cycles(2);
    n_chk++; if (fin_c.size() != 0) $display("FAIL rstmid_fin: got %0d pulses want 0", fin_c.size()); else n_pass++;
    start_frame();
    put_sym(4'd1, 1'b1, ok0);
    idle_cycles(6);
    n_chk++; if ({ok0, obs_q.size() == 3, obs_q[0], obs_q[1], obs_q[2], fin_c.size() == 1, fin_err, fin_tot} !== {7'b1111110, 4'd3})
      $display("FAIL rstmid_again: got ok=%b bits=%0d fins=%0d err=%b total=%0d want 1, 111, 1, 0, 3", ok0, obs_q.size(), fin_c.size(), fin_err, fin_tot);
    else n_pass++;
  endtask

  initial begin
    tbl_t = '{13'h0401, 13'h0607, 13'h0601, 13'h0808, 13'h0605,
              13'h0809, 13'h0a01, 13'h0801, 13'h0a00, 13'h0606};
    for (int i = 0; i < 10; i++) code_in[i] = tbl_t[i];
    n_rst = 1'b0; start = 1'b0; sym = '0; sym_vld = 1'b0; sym_last = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    n_rst = 1'b1;
    test_stream();
    test_stall();
    test_illegal();
    test_snapshot();
    test_bounds();
    test_start_in_shift();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule
